instr_fetch: RTL and testbench

Instruction fetch stage for the 8-bit-address, 24-bit-instruction CPU. It owns the program counter and drives the combinational-read 256x24 instruction memory. It latches the returned word into an instruction register and hands it to decode over a valid/ready handshake. It also accepts PC redirects from execute for jumps and branches, and stops fetching on a HALT opcode.

---
 rtl/instr_fetch.sv | 139 +++++++++++++
 tb/tb_instr_fetch.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
// Instruction fetch stage: owns the PC, reads a combinational 256x24
// instruction memory, latches the word into an instruction register and
// offers it to decode over a valid/ready handshake. Execute can redirect the
// PC at any time after boot; a HALT opcode stops fetching until the next
// redirect.
//
// Optional build macro: FETCH_PERF_EN adds the fetch_cnt / stall_cnt
// saturating performance counters and their ports.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module instr_fetch #(
    parameter logic [7:0] RESET_PC = 8'h00,
    parameter logic [5:0] HALT_OP  = 6'b111111
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [7:0]  imem_addr,
    input  logic [23:0] imem_dout,
    input  logic        redirect_vld,
    input  logic [7:0]  redirect_pc,
    output logic        ir_vld,
    input  logic        ir_rdy,
    output logic [23:0] ir_data,
    output logic [7:0]  ir_pc,
    output logic        halted
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0] fetch_cnt,
    output logic [15:0] stall_cnt
`endif
);

    // BOOT gives memory one quiet cycle after reset, RUN fetches, HALT idles
    // until execute redirects.
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [7:0]  pc_q;
    logic        fetch;
    logic        take_redirect;
    logic        fetch_is_halt;

    // The memory address is the PC register itself, so the fetched word is
    // available in the same cycle the PC points at it.
    assign imem_addr = pc_q;

    // Fetch/redirect decisions and next-state selection. A redirect blocks a
    // fetch in the same cycle, which is also why a redirect beats a HALT word
    // sitting at the PC.
    always_comb begin
        take_redirect = 1'b0;
        fetch         = 1'b0;
        fetch_is_halt = 1'b0;
        state_d       = state_q;

        take_redirect = redirect_vld && (state_q != ST_BOOT);
        fetch         = (state_q == ST_RUN) && (!ir_vld || ir_rdy) && !redirect_vld;
        fetch_is_halt = fetch && (imem_dout[23:18] == HALT_OP);

        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (take_redirect) begin
                    state_d = ST_RUN;
                end else if (fetch_is_halt) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                if (take_redirect) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    // State register, with halted registered alongside so it always equals
    // (state == HALT) without a decode after the flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            halted  <= 1'b0;
        end else begin
            state_q <= state_d;
            halted  <= (state_d == ST_HALT);
        end
    end

    // PC and instruction register. Redirect flushes the IR and reloads the
    // PC; otherwise a fetch loads the IR and advances the PC (wrapping at
    // 255), and a consumed instruction with nothing to replace it clears
    // valid. With valid high and ready low everything simply holds.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            ir_vld  <= 1'b0;
            ir_data <= 24'h000000;
            ir_pc   <= 8'h00;
        end else if (take_redirect) begin
            pc_q   <= redirect_pc;
            ir_vld <= 1'b0;
        end else if (fetch) begin
            ir_data <= imem_dout;
            ir_pc   <= pc_q;
            ir_vld  <= 1'b1;
            pc_q    <= pc_q + 8'd1;
        end else if (ir_vld && ir_rdy) begin
            ir_vld <= 1'b0;
        end
    end

`ifdef FETCH_PERF_EN
    // Saturating fetch and stall counters; nothing is counted while booting
    // and only reset clears them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_cnt <= 16'h0000;
            stall_cnt <= 16'h0000;
        end else if (state_q != ST_BOOT) begin
            if (fetch && (fetch_cnt != 16'hFFFF)) begin
                fetch_cnt <= fetch_cnt + 16'd1;
            end
            if (ir_vld && !ir_rdy && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
// Self-checking bench for instr_fetch. Directed scenarios cover boot timing,
// stalls, redirects, PC wrap, HALT and reset; a randomized phase checks the
// delivered instruction stream against a stream-level reference (next
// expected address and the memory image). Build with FETCH_PERF_EN to also
// check the performance counters.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  imem_addr;
    logic [23:0] imem_dout;
    logic        redirect_vld;
    logic [7:0]  redirect_pc;
    logic        ir_vld;
    logic        ir_rdy;
    logic [23:0] ir_data;
    logic [7:0]  ir_pc;
    logic        halted;
`ifdef FETCH_PERF_EN
    logic [15:0] fetch_cnt;
    logic [15:0] stall_cnt;
`endif

    logic [23:0] mem [256];
    int          tests = 0;
    int          fails = 0;

    // Free-running clock
    always #5 clk = ~clk;

    // Combinational instruction memory model
    assign imem_dout = mem[imem_addr];

    instr_fetch #(
        .RESET_PC (8'h00),
        .HALT_OP  (6'b111111)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_addr    (imem_addr),
        .imem_dout    (imem_dout),
        .redirect_vld (redirect_vld),
        .redirect_pc  (redirect_pc),
        .ir_vld       (ir_vld),
        .ir_rdy       (ir_rdy),
        .ir_data      (ir_data),
        .ir_pc        (ir_pc),
        .halted       (halted)
`ifdef FETCH_PERF_EN
        ,
        .fetch_cnt    (fetch_cnt),
        .stall_cnt    (stall_cnt)
`endif
    );

    // Default memory image: opcode 1, address-dependent payload
    function automatic logic [23:0] word_at(input int a);
        logic [7:0] b;
        b = 8'(a);
        return {6'h01, 2'b00, b, b ^ 8'hA5};
    endfunction

    task automatic load_default_mem;
        for (int i = 0; i < 256; i++) mem[i] = word_at(i);
    endtask

    // One rising edge; outputs are then observed 1ns later
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n        = 1'b0;
        ir_rdy       = 1'b1;
        redirect_vld = 1'b0;
        redirect_pc  = 8'h00;
        tick;
        tick;
        tests++;
        if ({ir_vld, imem_addr, ir_pc, ir_data, halted} !== {1'b0, 8'h00, 8'h00, 24'h0, 1'b0}) begin
            fails++;
            $display("[TB] FAIL reset_values got vld=%0b addr=%h pc=%h data=%h halted=%0b want 0/00/00/000000/0",
                     ir_vld, imem_addr, ir_pc, ir_data, halted);
        end
`ifdef FETCH_PERF_EN
        tests++;
        if ({fetch_cnt, stall_cnt} !== 32'h0) begin
            fails++;
            $display("[TB] FAIL reset_counters got fetch=%0d stall=%0d want 0/0", fetch_cnt, stall_cnt);
        end
`endif
    endtask

    task automatic test_sequential;
        rst_n  = 1'b1;
        ir_rdy = 1'b1;
        tick;
        tests++;
        if ({ir_vld, halted, imem_addr} !== {1'b0, 1'b0, 8'h00}) begin
            fails++;
            $display("[TB] FAIL boot_cycle got vld=%0b halted=%0b addr=%h want 0/0/00", ir_vld, halted, imem_addr);
        end
        for (int k = 0; k < 6; k++) begin
            tick;
            tests++;
            if ({ir_vld, ir_pc, ir_data, imem_addr} !== {1'b1, 8'(k), word_at(k), 8'(k + 1)}) begin
                fails++;
                $display("[TB] FAIL seq_fetch[%0d] got vld=%0b pc=%h data=%h addr=%h want 1/%h/%h/%h",
                         k, ir_vld, ir_pc, ir_data, imem_addr, 8'(k), word_at(k), 8'(k + 1));
            end
        end
`ifdef FETCH_PERF_EN
        tests++;
        if (fetch_cnt !== 16'd6) begin
            fails++;
            $display("[TB] FAIL seq_fetch_cnt got %0d want 6", fetch_cnt);
        end
`endif
    endtask

    task automatic test_stall;
        logic [15:0] base;
        base = 16'h0;
        redirect_vld = 1'b1;
        redirect_pc  = 8'h05;
        ir_rdy       = 1'b1;
        tick;
        redirect_vld = 1'b0;
        ir_rdy       = 1'b0;
        tick;
        tests++;
        if ({ir_vld, ir_pc, imem_addr} !== {1'b1, 8'h05, 8'h06}) begin
            fails++;
            $display("[TB] FAIL stall_setup got vld=%0b pc=%h addr=%h want 1/05/06", ir_vld, ir_pc, imem_addr);
        end
`ifdef FETCH_PERF_EN
        base = stall_cnt;
`endif
        for (int k = 0; k < 3; k++) begin
            tick;
            tests++;
            if ({ir_vld, ir_pc, ir_data, imem_addr} !== {1'b1, 8'h05, word_at(5), 8'h06}) begin
                fails++;
                $display("[TB] FAIL stall_hold[%0d] got vld=%0b pc=%h data=%h addr=%h want 1/05/%h/06",
                         k, ir_vld, ir_pc, ir_data, imem_addr, word_at(5));
            end
        end
`ifdef FETCH_PERF_EN
        tests++;
        if (stall_cnt !== base + 16'd3) begin
            fails++;
            $display("[TB] FAIL stall_cnt got %0d want %0d", stall_cnt, base + 16'd3);
        end
`endif
        ir_rdy = 1'b1;
        tick;
        tests++;
        if ({ir_vld, ir_pc, imem_addr} !== {1'b1, 8'h06, 8'h07}) begin
            fails++;
            $display("[TB] FAIL stall_release got vld=%0b pc=%h addr=%h want 1/06/07", ir_vld, ir_pc, imem_addr);
        end
    endtask

    task automatic test_redirect;
        ir_rdy = 1'b1;
        tick;
        ir_rdy       = 1'b0;
        redirect_vld = 1'b1;
        redirect_pc  = 8'h1B;
        tick;
        tests++;
        if ({ir_vld, imem_addr} !== {1'b0, 8'h1B}) begin
            fails++;
            $display("[TB] FAIL redirect_flush got vld=%0b addr=%h want 0/1b", ir_vld, imem_addr);
        end
        redirect_vld = 1'b0;
        ir_rdy       = 1'b1;
        tick;
        tests++;
        if ({ir_vld, ir_pc, ir_data} !== {1'b1, 8'h1B, word_at(8'h1B)}) begin
            fails++;
            $display("[TB] FAIL redirect_target got vld=%0b pc=%h data=%h want 1/1b/%h",
                     ir_vld, ir_pc, ir_data, word_at(8'h1B));
        end
    endtask

    task automatic test_wrap;
        logic [7:0] expect_pc;
        ir_rdy       = 1'b1;
        redirect_vld = 1'b1;
        redirect_pc  = 8'hFE;
        tick;
        redirect_vld = 1'b0;
        expect_pc    = 8'hFE;
        for (int k = 0; k < 4; k++) begin
            tick;
            tests++;
            if ({ir_vld, ir_pc, imem_addr} !== {1'b1, expect_pc, expect_pc + 8'd1}) begin
                fails++;
                $display("[TB] FAIL wrap[%0d] got vld=%0b pc=%h addr=%h want 1/%h/%h",
                         k, ir_vld, ir_pc, imem_addr, expect_pc, expect_pc + 8'd1);
            end
            expect_pc = expect_pc + 8'd1;
        end
    endtask

    task automatic test_halt;
        mem[3]       = {6'b111111, 18'h2ABCD};
        ir_rdy       = 1'b1;
        redirect_vld = 1'b1;
        redirect_pc  = 8'h00;
        tick;
        redirect_vld = 1'b0;
        tick;
        tick;
        tick;
        tick;
        tests++;
        if ({ir_vld, ir_pc, ir_data, halted, imem_addr} !== {1'b1, 8'h03, mem[3], 1'b1, 8'h04}) begin
            fails++;
            $display("[TB] FAIL halt_deliver got vld=%0b pc=%h data=%h halted=%0b addr=%h want 1/03/%h/1/04",
                     ir_vld, ir_pc, ir_data, halted, imem_addr, mem[3]);
        end
        for (int k = 0; k < 5; k++) begin
            tick;
            tests++;
            if ({ir_vld, halted, imem_addr} !== {1'b0, 1'b1, 8'h04}) begin
                fails++;
                $display("[TB] FAIL halt_idle[%0d] got vld=%0b halted=%0b addr=%h want 0/1/04",
                         k, ir_vld, halted, imem_addr);
            end
        end
        redirect_vld = 1'b1;
        redirect_pc  = 8'h00;
        tick;
        redirect_vld = 1'b0;
        tests++;
        if ({ir_vld, halted, imem_addr} !== {1'b0, 1'b0, 8'h00}) begin
            fails++;
            $display("[TB] FAIL halt_resume got vld=%0b halted=%0b addr=%h want 0/0/00", ir_vld, halted, imem_addr);
        end
        tick;
        tests++;
        if ({ir_vld, ir_pc, halted} !== {1'b1, 8'h00, 1'b0}) begin
            fails++;
            $display("[TB] FAIL halt_refetch got vld=%0b pc=%h halted=%0b want 1/00/0", ir_vld, ir_pc, halted);
        end
    endtask

    // Redirect arrives while the PC points at the HALT word
    task automatic test_back_to_back;
        ir_rdy = 1'b1;
        tick;
        tick;
        redirect_vld = 1'b1;
        redirect_pc  = 8'h40;
        tick;
        redirect_vld = 1'b0;
        tests++;
        if ({ir_vld, halted, imem_addr} !== {1'b0, 1'b0, 8'h40}) begin
            fails++;
            $display("[TB] FAIL redirect_beats_halt got vld=%0b halted=%0b addr=%h want 0/0/40",
                     ir_vld, halted, imem_addr);
        end
        tick;
        tests++;
        if ({ir_vld, ir_pc, halted} !== {1'b1, 8'h40, 1'b0}) begin
            fails++;
            $display("[TB] FAIL redirect_beats_halt_target got vld=%0b pc=%h halted=%0b want 1/40/0",
                     ir_vld, ir_pc, halted);
        end
        mem[3] = word_at(3);
    endtask

    // Random ready/redirect traffic; the reference is the expected address
    // of the next instruction decode should receive.
    task automatic test_random;
        logic [7:0]  exp_next;
        logic [7:0]  prev_pc;
        logic [23:0] prev_data;
        bit          prev_stall;
        int          delivered;
        int          halt_seen;
        prev_stall = 1'b0;
        prev_pc    = 8'h00;
        prev_data  = 24'h0;
        delivered  = 0;
        halt_seen  = 0;
        for (int i = 0; i < 256; i++) mem[i] = {6'($urandom_range(0, 62)), 18'($urandom)};
        ir_rdy       = 1'b1;
        redirect_vld = 1'b1;
        redirect_pc  = 8'($urandom);
        exp_next     = redirect_pc;
        tick;
        redirect_vld = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            ir_rdy       = ($urandom_range(0, 9) < 7);
            redirect_vld = ($urandom_range(0, 11) == 0);
            redirect_pc  = 8'($urandom);
            if (prev_stall) begin
                tests++;
                if ({ir_vld, ir_pc, ir_data} !== {1'b1, prev_pc, prev_data}) begin
                    fails++;
                    $display("[TB] FAIL rand_hold[%0d] got vld=%0b pc=%h data=%h want 1/%h/%h",
                             c, ir_vld, ir_pc, ir_data, prev_pc, prev_data);
                end
            end
            if (ir_vld && ir_rdy) begin
                tests++;
                if ({ir_pc, ir_data} !== {exp_next, mem[exp_next]}) begin
                    fails++;
                    $display("[TB] FAIL rand_stream[%0d] got pc=%h data=%h want %h/%h",
                             c, ir_pc, ir_data, exp_next, mem[exp_next]);
                end
                exp_next = exp_next + 8'd1;
                delivered++;
            end
            if (halted) halt_seen++;
            if (redirect_vld) exp_next = redirect_pc;
            prev_stall = ir_vld && !ir_rdy && !redirect_vld;
            prev_pc    = ir_pc;
            prev_data  = ir_data;
            tick;
        end
        redirect_vld = 1'b0;
        tests++;
        if (delivered < 600 || halt_seen != 0) begin
            fails++;
            $display("[TB] FAIL rand_progress got delivered=%0d halted_cycles=%0d want >=600/0",
                     delivered, halt_seen);
        end
        load_default_mem;
    endtask

    task automatic test_reset_mid_stall;
        ir_rdy       = 1'b1;
        redirect_vld = 1'b1;
        redirect_pc  = 8'h30;
        tick;
        redirect_vld = 1'b0;
        ir_rdy       = 1'b0;
        tick;
        tick;
        tests++;
        if ({ir_vld, ir_pc} !== {1'b1, 8'h30}) begin
            fails++;
            $display("[TB] FAIL mid_stall_setup got vld=%0b pc=%h want 1/30", ir_vld, ir_pc);
        end
        rst_n = 1'b0;
        tick;
        tests++;
        if ({ir_vld, imem_addr, ir_pc, ir_data, halted} !== {1'b0, 8'h00, 8'h00, 24'h0, 1'b0}) begin
            fails++;
            $display("[TB] FAIL mid_stall_reset got vld=%0b addr=%h pc=%h data=%h halted=%0b want 0/00/00/000000/0",
                     ir_vld, imem_addr, ir_pc, ir_data, halted);
        end
`ifdef FETCH_PERF_EN
        tests++;
        if ({fetch_cnt, stall_cnt} !== 32'h0) begin
            fails++;
            $display("[TB] FAIL mid_stall_counters got fetch=%0d stall=%0d want 0/0", fetch_cnt, stall_cnt);
        end
`endif
        rst_n  = 1'b1;
        ir_rdy = 1'b1;
        tick;
        tests++;
        if ({ir_vld, imem_addr} !== {1'b0, 8'h00}) begin
            fails++;
            $display("[TB] FAIL mid_stall_boot got vld=%0b addr=%h want 0/00", ir_vld, imem_addr);
        end
        tick;
        tests++;
        if ({ir_vld, ir_pc, ir_data} !== {1'b1, 8'h00, word_at(0)}) begin
            fails++;
            $display("[TB] FAIL mid_stall_refetch got vld=%0b pc=%h data=%h want 1/00/%h",
                     ir_vld, ir_pc, ir_data, word_at(0));
        end
    endtask

    initial begin
        load_default_mem;
        test_reset;
        test_sequential;
        test_stall;
        test_redirect;
        test_wrap;
        test_halt;
        test_back_to_back;
        test_random;
        test_reset_mid_stall;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
